a2d_round_robin: RTL and testbench

//  SPI master front end for the 12-bit ADC128S A2D on the Segway board.
//  - Each nxt pulse converts one channel, in a fixed rotation:

---
 rtl/a2d_round_robin_pkg.sv | 32 +++
 rtl/a2d_round_robin_spi.sv | 83 ++++++++
 rtl/a2d_round_robin.sv | 112 +++++++++++
 tb/tb_a2d_round_robin.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_round_robin_pkg.sv
// Shared FSM/selector types and ADC128S channel constants for the
// round-robin A2D front end.
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        GAP,
        READ
    } a2d_state_t;

    // Rotation pointer: which result register the next conversion targets.
    typedef enum logic [1:0] {
        SEL_LFT,
        SEL_RGHT,
        SEL_BATT
    } a2d_sel_t;

    localparam logic [2:0] CH_LFT_DEF  = 3'd0;
    localparam logic [2:0] CH_RGHT_DEF = 3'd4;
    localparam logic [2:0] CH_BATT_DEF = 3'd5;
    localparam logic [1:0] CMD_PREFIX  = 2'b00;

    function automatic a2d_sel_t next_sel(input a2d_sel_t sel);
        case (sel)
            SEL_LFT:  return SEL_RGHT;
            SEL_RGHT: return SEL_BATT;
            default:  return SEL_LFT;
        endcase
    endfunction

endpackage

// File: rtl/a2d_round_robin_spi.sv
// 16-bit SPI master (CPOL=1, CPHA=1): MSB first, MISO sampled just before
// each SCLK rise, shift register doubles as tx and rx.
module spi_monarch16 #(
    parameter int unsigned SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] tx,
    output logic [15:0] rx,
    output logic        done,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam logic [SCLK_DIV_W-1:0] DIV_LOAD = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_SMP  = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;

    logic                  active;
    logic                  first_fall;
    logic                  smp_bit;
    logic [SCLK_DIV_W-1:0] div;
    logic [15:0]           shft;
    logic [4:0]            smp_cnt;
    logic                  ss_n_q;
    logic                  done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active     <= 1'b0;
            first_fall <= 1'b0;
            smp_bit    <= 1'b0;
            div        <= '1;
            shft       <= '0;
            smp_cnt    <= '0;
            ss_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!active) begin
                if (wrt) begin
                    active     <= 1'b1;
                    first_fall <= 1'b1;
                    div        <= DIV_LOAD;
                    shft       <= tx;
                    smp_cnt    <= '0;
                end
            end else begin
                ss_n_q <= 1'b0;
                div    <= div + 1'b1;
                if (div == DIV_SMP) begin
                    smp_bit <= MISO;
                    smp_cnt <= smp_cnt + 1'b1;
                end
                if (div == DIV_FALL) begin
                    // The terminating step holds SCLK high but still shifts in
                    // the 16th sample so rx is complete when done fires.
                    if (smp_cnt == 5'd16) begin
                        active <= 1'b0;
                        ss_n_q <= 1'b1;
                        done_q <= 1'b1;
                        div    <= DIV_FALL;
                        shft   <= {shft[14:0], smp_bit};
                    end else if (first_fall) begin
                        first_fall <= 1'b0;
                    end else begin
                        shft <= {shft[14:0], smp_bit};
                    end
                end
            end
        end
    end

    assign SS_n = ss_n_q;
    assign SCLK = div[SCLK_DIV_W-1];
    assign MOSI = active & shft[15];
    assign rx   = shft;
    assign done = done_q;

endmodule

// File: rtl/a2d_round_robin.sv
// ADC128S round-robin front end: command/readback FSM, channel rotation
// pointer and the three result registers around one SPI master.
module a2d_round_robin
    import a2d_pkg::*;
#(
    parameter int unsigned SCLK_DIV_W = 5,
    parameter logic [2:0]  CH_LFT     = CH_LFT_DEF,
    parameter logic [2:0]  CH_RGHT    = CH_RGHT_DEF,
    parameter logic [2:0]  CH_BATT    = CH_BATT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt
);

    a2d_state_t  state;
    a2d_state_t  state_nxt;
    a2d_sel_t    sel;
    logic        wrt;
    logic        done;
    logic        res_wr;
    logic [15:0] tx;
    logic [15:0] rx;
    logic [2:0]  cur_ch;
    logic        unused_rx_hi;

    assign unused_rx_hi = ^rx[15:12];

    always_comb begin
        case (sel)
            SEL_LFT:  cur_ch = CH_LFT;
            SEL_RGHT: cur_ch = CH_RGHT;
            default:  cur_ch = CH_BATT;
        endcase
    end

    always_comb begin
        state_nxt = state;
        wrt       = 1'b0;
        tx        = '0;
        res_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (nxt) begin
                    wrt       = 1'b1;
                    tx        = {CMD_PREFIX, cur_ch, 11'h000};
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (done) state_nxt = GAP;
            end
            GAP: begin
                wrt       = 1'b1;
                state_nxt = READ;
            end
            READ: begin
                if (done) begin
                    res_wr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= SEL_LFT;
            lft_ld    <= '0;
            rght_ld   <= '0;
            batt      <= '0;
            cnv_cmplt <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnv_cmplt <= res_wr;
            if (res_wr) begin
                case (sel)
                    SEL_LFT:  lft_ld  <= rx[11:0];
                    SEL_RGHT: rght_ld <= rx[11:0];
                    default:  batt    <= rx[11:0];
                endcase
                sel <= next_sel(sel);
            end
        end
    end

    spi_monarch16 #(
        .SCLK_DIV_W(SCLK_DIV_W)
    ) u_spi (
        .clk (clk),
        .rst (rst),
        .wrt (wrt),
        .tx  (tx),
        .rx  (rx),
        .done(done),
        .SS_n(SS_n),
        .SCLK(SCLK),
        .MOSI(MOSI),
        .MISO(MISO)
    );

endmodule

// File: tb/tb_a2d_round_robin.sv
// Bench for a2d_round_robin: mode-3 ADC slave, cycle-count conversion model
// and directed conversion/abort sequences.
module tb_a2d_round_robin;

    localparam int LATENCY = 1046;
    localparam int SS_LOW  = 520;
    // SS_n high between transactions: done cycle, one GAP clk, SPI load clk.
    localparam int GAP_HI  = 3;
    localparam int RISES   = 16;
    localparam logic [15:0] JUNK = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic        MISO = 1'b0;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;
    logic        cnv_cmplt;

    a2d_round_robin dut (
        .clk      (clk),
        .rst      (rst),
        .nxt      (nxt),
        .MISO     (MISO),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .batt     (batt),
        .cnv_cmplt(cnv_cmplt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Conversion model: a result lands LATENCY clk after the cycle nxt is seen.
    logic [2:0]  chans [3] = '{3'd0, 3'd4, 3'd5};
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_due = 0;
    int          m_ptr = 0;
    logic [11:0] m_res [3];
    logic        m_cnv = 1'b0;
    logic [15:0] m_word = '0;
    logic [15:0] m_cmd = '0;
    logic [15:0] rd_word = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
            m_cnv  = 1'b0;
            for (int i = 0; i < 3; i++) m_res[i] = '0;
        end else begin
            m_cnv = 1'b0;
            if (m_busy && cyc == m_due) begin
                m_res[m_ptr] = m_word[11:0];
                m_ptr        = (m_ptr + 1) % 3;
                m_cnv        = 1'b1;
                m_busy       = 0;
            end else if (!m_busy && nxt) begin
                m_busy = 1;
                m_due  = cyc + LATENCY - 1;
                m_word = rd_word;
                m_cmd  = {2'b00, chans[m_ptr], 11'h000};
            end
        end
    end

    int cnv_cnt = 0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("outputs", {cnv_cmplt, lft_ld, rght_ld, batt},
                  {m_cnv, m_res[0], m_res[1], m_res[2]});
            if (cnv_cmplt === 1'b1) cnv_cnt++;
        end
    end

    // ADC slave and SPI timing monitor (mode 3: drive on fall, master samples on rise).
    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b1;
    logic [15:0] sh = '0;
    logic [15:0] mosi_w = '0;
    logic [15:0] last_cmd = '0;
    bit          txn_sel = 0;
    bit          cur_txn = 0;
    int          low_cnt = 0;
    int          hi_cnt = 0;
    int          rises = 0;
    int          sclk_bad = 0;

    always @(negedge clk) begin
        if (rst) begin
            txn_sel  = 0;
            low_cnt  = 0;
            hi_cnt   = 0;
            rises    = 0;
            sclk_bad = 0;
            MISO     = 1'b0;
        end else begin
            if (prev_ss === 1'b1 && SS_n === 1'b0) begin
                if (txn_sel) check("gap_ss_high", hi_cnt, GAP_HI);
                check("sclk_idle", sclk_bad, 0);
                cur_txn  = txn_sel;
                txn_sel  = !txn_sel;
                sh       = cur_txn ? rd_word : JUNK;
                low_cnt  = 0;
                rises    = 0;
                mosi_w   = '0;
                sclk_bad = 0;
            end
            if (prev_ss === 1'b0 && SS_n === 1'b1) begin
                check("ss_low_len", low_cnt, SS_LOW);
                check("sclk_rises", rises, RISES);
                if (!cur_txn) begin
                    last_cmd = mosi_w;
                    check("cmd_word", mosi_w, m_cmd);
                end else begin
                    check("read_mosi", mosi_w, 16'h0000);
                end
                hi_cnt = 0;
            end
            if (SS_n === 1'b1 && SCLK !== prev_sclk) sclk_bad++;
            if (SS_n === 1'b0 && prev_sclk === 1'b0 && SCLK === 1'b1) begin
                rises++;
                mosi_w = {mosi_w[14:0], MOSI};
            end
            if (SS_n === 1'b0 && prev_sclk === 1'b1 && SCLK === 1'b0) begin
                MISO = sh[15];
                sh   = {sh[14:0], 1'b0};
            end
            if (SS_n === 1'b1) hi_cnt++;
            else low_cnt++;
        end
        prev_ss   = SS_n;
        prev_sclk = SCLK;
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_conv(input string tag, input logic [15:0] w,
                           input logic [15:0] exp_cmd, input bit pester);
        int n;
        int c0;
        rd_word = w;
        c0 = cnv_cnt;
        @(posedge clk);
        #1 nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
        n = 1;
        while (cnv_cmplt !== 1'b1 && n < 2 * LATENCY) begin
            @(posedge clk);
            #1;
            n++;
            // extra pulses land in CMD, in READ, and on the READ-done clk
            nxt = pester && (n == 100 || n == 700 || n == 1045);
        end
        nxt = 1'b0;
        check({tag, "_latency"}, n, LATENCY);
        check({tag, "_cmd"}, last_cmd, exp_cmd);
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_one_pulse"}, cnv_cnt - c0, 1);
        check({tag, "_idle_after"}, SS_n, 1'b1);
    endtask

    initial begin
        int n;
        int c0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_SS_n", SS_n, 1'b1);
        check("rst_SCLK", SCLK, 1'b1);
        check("rst_MOSI", MOSI, 1'b0);
        check("rst_cnv", cnv_cmplt, 1'b0);
        check("rst_results", {lft_ld, rght_ld, batt}, 36'h0);

        do_conv("t1", 16'hF123, 16'h0000, 0);
        check("t1_lft", lft_ld, 12'h123);

        do_reset();
        do_conv("t2a", 16'h0A5A, 16'h0000, 0);
        do_conv("t2b", 16'h53C3, 16'h2000, 0);
        do_conv("t2c", 16'hB7FF, 16'h2800, 0);
        check("t2_results", {lft_ld, rght_ld, batt}, {12'hA5A, 12'h3C3, 12'h7FF});

        do_conv("t3_wrap", 16'hC456, 16'h0000, 1);
        check("t3_results", {lft_ld, rght_ld, batt}, {12'h456, 12'h3C3, 12'h7FF});

        // Abort: rst lands at clk 300 of the READ transaction (right channel).
        rd_word = 16'h0777;
        c0 = cnv_cnt;
        @(posedge clk);
        #1 nxt = 1'b1;
        @(posedge clk);
        #1 nxt = 1'b0;
        n = 1;
        while (n < 824) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_cmd", last_cmd, 16'h2000);
        check("abort_in_read", SS_n, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ss_next", SS_n, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_results", {lft_ld, rght_ld, batt}, 36'h0);
        check("abort_no_pulse", cnv_cnt - c0, 0);
        do_conv("t4_after_abort", 16'h0BCD, 16'h0000, 0);
        check("t4_lft", lft_ld, 12'hBCD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d",
                 vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
